inst_encoder: RTL and testbench
===============================

# inst_encoder

Assembles RV32I instruction words from individual fields (opcode, funct3, funct7, rd, rs1, rs2, immediate) and a format selector, performing the inverse of field extraction. Each accepted request is packed into a 32-bit word and buffered in an output FIFO with valid/ready handshakes on both sides. It sits in the test and program-generation path, ahead of instruction memory or a loader, and produces the words that the decode stage later splits back into fields.

## Interface
- DEPTH, 4: output FIFO entries; power of two, at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder can accept a request this cycle.
- in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  placed in inst[6:0].
- in_funct3  input  3  placed in inst[14:12] for R, I, S and B.
- in_funct7  input  7  placed in inst[31:25] for R only.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  32  immediate, byte offset for B and J.
- out_valid  output  1  head word available.
- out_ready  input  1  consumer takes the head word.
- out_inst  output  32  encoded instruction at the FIFO head.
- out_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err_fmt  output  1  one-cycle pulse when an illegal-format request is accepted.

## Operation
- Packing per format (fields concatenated MSB to LSB):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I: imm[11:0] | rs1 | funct3 | rd | opcode
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U: imm[31:12] | rd | opcode
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
- Immediate bits outside the listed slices are ignored, including imm[0] for B and J. There is no range or alignment check.
- Fields not used by a format are ignored.
- Accept: in_valid && in_ready. A legal request writes its packed word at wr_ptr; wr_ptr increments.
- Illegal in_fmt, when accepted: nothing is written. err_fmt is 1 in the following cycle; count and pointers are unchanged.
- Pop: out_valid && out_ready. rd_ptr increments.
- FIFO: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register tracks occupancy.
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- in_ready = (count != DEPTH). It is combinational from the count register and does not depend on out_ready, so there is no pass-through when full.
- out_valid = (count != 0).
- out_inst = mem[rd_ptr] when out_valid, otherwise 32'h0.
- Ordering is strict FIFO.

## Timing
- Reset, effective at the next edge:
  - count, wr_ptr, rd_ptr = 0
  - out_valid = 0
  - out_inst = 0
  - out_count = 0
  - err_fmt = 0
  - in_ready = 1 in the cycle after reset
- FIFO storage is not reset.
- rst takes priority over push and pop in the same cycle. Any in-flight request is dropped and buffered words are discarded.
- Latency: a request accepted in cycle N appears on out_inst with out_valid = 1 in cycle N+1 if the FIFO was empty. Otherwise it appears behind earlier entries.
- With the FIFO empty and out_ready = 1 held, throughput is one word per cycle.
- While out_valid && !out_ready, out_inst and out_valid stay stable.
- Full FIFO: in_ready = 0 even when out_ready = 1. After a pop, in_ready rises in the next cycle.
- Push and pop in the same cycle with count = 1: count stays 1, and out_inst shows the new word in the next cycle.
- err_fmt lasts exactly one cycle per illegal accept. Back-to-back illegal requests give a continuous high level.

## Test plan
- R: fmt 0, opcode 0x33, funct3 0, funct7 0, rd 3, rs1 1, rs2 2 -> out_inst 0x002081B3 in the next cycle.
- I and S:
  - fmt 1, op 0x13, rd 5, rs1 0, imm 0xFFFFFFFF -> 0xFFF00293
  - fmt 2, op 0x23, funct3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423
- B, U, J:
  - B, op 0x63, rs1 1, rs2 2, imm -4 -> 0xFE208EE3
  - U, op 0x37, rd 10, imm 0x12345000 -> 0x12345537
  - J, op 0x6F, rd 1, imm 0x800 -> 0x001000EF
- Backpressure, DEPTH 4, out_ready = 0: offer 5 requests.
  - in_ready drops after the 4th accept; out_count = 4.
  - Raise out_ready: 4 words in order, then the 5th is accepted and emitted.
  - Pointers wrap correctly over 3 passes.
- Illegal format: fmt 6 with in_valid -> accepted; err_fmt high for exactly 1 cycle; out_count unchanged; a following legal request encodes normally.
- Reset mid-stream: with 3 words buffered and out_ready = 0, pulse rst for 1 cycle.
  - Next cycle: out_valid 0, out_count 0, out_inst 0, in_ready 1.
  - A new request then emerges first.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction word assembler: packs individual fields per format into a
// 32-bit word and buffers it in a small valid/ready output FIFO.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     err_fmt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_fmt;

  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_inst  = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign out_count = r_count;
  assign err_fmt   = r_err_fmt;

  assign w_accept  = in_valid && in_ready;
  assign w_legal   = (in_fmt <= 3'd5);
  assign w_push    = w_accept && w_legal;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_word = 32'h0;
    case (in_fmt)
      FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: w_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, in_opcode};
      default: w_word = 32'h0;
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_fmt <= 1'b0;
    end else begin
      r_err_fmt <= w_accept && !w_legal;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: known-answer encodings, backpressure
// with pointer wrap, illegal formats and mid-stream reset, via a queue scoreboard.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [2:0]  out_count;
  logic        err_fmt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_count(out_count), .err_fmt(err_fmt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (err_fmt !== 1'b0) begin errors++; $display("FAIL reset_err_fmt got=%b exp=0", err_fmt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_r_format();
    @(negedge clk);
    out_ready = 1'b1;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r_in_ready got=%b exp=1", in_ready); end
    exp_q.push_back(32'h002081B3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL r_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_inst !== exp_q[0]) begin errors++; $display("FAIL r_out_inst got=%h exp=%h", out_inst, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL r_drained got=%b exp=0", out_valid); end
  endtask

  // Back-to-back known answers: each cycle checks the previous word while the next is pushed.
  task automatic test_back_to_back();
    logic [2:0]  fmts [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [6:0]  ops  [5] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F};
    logic [2:0]  f3s  [5] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [4:0]  rds  [5] = '{5'd5, 5'd0, 5'd0, 5'd10, 5'd1};
    logic [4:0]  rs1s [5] = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
    logic [4:0]  rs2s [5] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
    logic [31:0] imms [5] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h800};
    logic [31:0] exps [5] = '{32'hFFF00293, 32'h0020A423, 32'hFE208EE3, 32'h12345537, 32'h001000EF};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (exp_q.size() != 0) begin
        checks++; if (out_valid !== 1'b1 || out_inst !== exp_q[0]) begin
          errors++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i - 1, out_valid, out_inst, exp_q[0]);
        end
        checks++; if (out_count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=1", i, out_count); end
        void'(exp_q.pop_front());
      end
      if (i < 5) begin
        drive(fmts[i], ops[i], f3s[i], 7'h7F, rds[i], rs1s[i], rs2s[i], imms[i]);
        exp_q.push_back(exps[i]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    for (int pass = 0; pass < 3; pass++) begin
      bit accepted;
      int cyc;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        logic [4:0] rd = 5'(pass * 5 + i);
        drive(3'd0, 7'h33, 3'(i), 7'(pass + 1), rd, 5'(i + 7), 5'(31 - i), 32'h0);
        checks++; if (in_ready !== (i < 4)) begin
          errors++; $display("FAIL bp_in_ready p%0d i%0d got=%b exp=%b", pass, i, in_ready, (i < 4));
        end
        if (i < 4) begin
          exp_q.push_back(enc_r(7'(pass + 1), 5'(31 - i), 5'(i + 7), 3'(i), rd, 7'h33));
          @(negedge clk);
        end
      end
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL bp_full_count p%0d got=%0d exp=4", pass, out_count); end
      out_ready = 1'b1;
      accepted = 1'b0;
      cyc = 0;
      while (!(accepted && exp_q.size() == 0)) begin
        bit acc_now;
        if (cyc == 0) begin
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_no_pass p%0d got=%b exp=0", pass, in_ready); end
        end
        if (cyc == 1) begin
          checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop p%0d got=%b exp=1", pass, in_ready); end
        end
        acc_now = in_valid && in_ready;
        checks++; if (out_valid !== (exp_q.size() != 0)) begin
          errors++; $display("FAIL bp_out_valid p%0d c%0d got=%b exp=%b", pass, cyc, out_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
          checks++; if (out_inst !== exp_q[0]) begin
            errors++; $display("FAIL bp_order p%0d c%0d got=%h exp=%h", pass, cyc, out_inst, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (acc_now) begin
          exp_q.push_back(enc_r(7'(pass + 1), 5'(27), 5'(11), 3'(4), 5'(pass * 5 + 4), 7'h33));
          accepted = 1'b1;
        end
        @(negedge clk);
        if (accepted) in_valid = 1'b0;
        cyc++;
        if (cyc > 20) begin
          errors++; checks++; $display("FAIL bp_timeout p%0d got=%0d exp<=20 cycles", pass, cyc);
          exp_q.delete();
          break;
        end
      end
    end
  endtask

  task automatic test_illegal_fmt();
    logic [31:0] wa = {12'h123, 5'd4, 3'd1, 5'd9, 7'h13};
    logic [31:0] wb = {12'h7FF, 5'd6, 3'd7, 5'd2, 7'h13};
    logic [2:0]  seq_fmt [4] = '{3'd1, 3'd6, 3'd7, 3'd1};
    logic [2:0]  exp_cnt [5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    logic        exp_err [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        if (i == 3) drive(seq_fmt[i], 7'h13, 3'd7, 7'h0, 5'd2, 5'd6, 5'd0, 32'h0000F7FF);
        else        drive(seq_fmt[i], 7'h13, 3'd1, 7'h0, 5'd9, 5'd4, 5'd0, 32'hABCDE123);
        if (i == 0) exp_q.push_back(wa);
        if (i == 3) exp_q.push_back(wb);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (err_fmt !== exp_err[i]) begin errors++; $display("FAIL ill_err_fmt s%0d got=%b exp=%b", i, err_fmt, exp_err[i]); end
      checks++; if (out_count !== exp_cnt[i]) begin errors++; $display("FAIL ill_count s%0d got=%0d exp=%0d", i, out_count, exp_cnt[i]); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_inst !== exp_q[0]) begin
        errors++; $display("FAIL ill_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_inst, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd4, 7'h37, 3'd0, 7'h0, 5'(i + 1), 5'd0, 5'd0, 32'h00001000 * (i + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_count !== 3'd3) begin errors++; $display("FAIL rst_pre_count got=%0d exp=3", out_count); end
    rst = 1'b1;
    drive(3'd4, 7'h37, 3'd0, 7'h0, 5'd31, 5'd0, 5'd0, 32'hDEAD0000);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", out_count); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_mid_out_inst got=%h exp=0", out_inst); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    exp_q.delete();
    drive(3'd4, 7'h17, 3'd0, 7'h0, 5'd7, 5'd0, 5'd0, 32'hCAFEB000);
    exp_q.push_back(32'hCAFEB397);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_inst !== exp_q[0]) begin
      errors++; $display("FAIL rst_mid_first got=%b/%h exp=1/%h", out_valid, out_inst, exp_q[0]);
    end
    checks++; if (out_count !== 3'd1) begin errors++; $display("FAIL rst_mid_new_count got=%0d exp=1", out_count); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_r_format();
    test_back_to_back();
    test_backpressure();
    test_illegal_fmt();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
